// File: rtl/fb_scanout.sv
// fb_scanout -- display-side reader of the external framebuffer.
//
// Produces VGA-style timing (640x480 visible by default) from a half-size
// image by 2x2 pixel doubling. Even visible lines fetch H_ACTIVE/2 pixels
// from the framebuffer into an internal line buffer. Odd visible lines
// replay that buffer without touching the framebuffer.
//
// Optional feature: define FB_SCANOUT_PALETTE_EN to add the 12-bit rgb
// output, which is a 16-level grey ramp of the pixel index.
//
// Ports:
//   clk               pixel clock
//   rst               asynchronous reset, active-high
//   fb_data[3:0]      framebuffer output (one-cycle registered read latency)
//   fb_read           strobe: advance framebuffer read pointer
//   fb_reset_read_ptr strobe: framebuffer read pointer back to 0
//   hsync, vsync      active-low sync pulses
//   de                high during visible pixels
//   pixel[3:0]        colour index, 0 whenever de=0
//   vblank            high on rows V_ACTIVE..V_TOTAL-1
//   rgb[11:0]         {pixel,pixel,pixel} (only with FB_SCANOUT_PALETTE_EN)
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fb_data,
  output logic        fb_read,
  output logic        fb_reset_read_ptr,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [3:0]  pixel,
  output logic        vblank
`ifdef FB_SCANOUT_PALETTE_EN
  ,
  output logic [11:0] rgb
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);
  localparam int LB_DEPTH = H_ACTIVE / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [XW-1:0] X_ACT   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_HS_LO = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] X_HS_HI = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW-1:0] X_LAST  = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_VS_LO = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] Y_VS_HI = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_TOTAL - 1);

  // Raster counters
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;

  always_comb begin
    x_next = x_reg + XW'(1);
    y_next = y_reg;
    if (x_reg == X_LAST) begin
      x_next = '0;
      y_next = (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= Y_ACT;   // start of vertical front porch
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
    end
  end

  // Raw timing decode from the counters
  logic x_vis, y_vis, fetch_row;
  logic hs_raw, vs_raw, de_raw, vb_raw;
  logic wr_en;
  logic [LBW-1:0] col_addr;

  assign x_vis     = (x_reg < X_ACT);
  assign y_vis     = (y_reg < Y_ACT);
  assign fetch_row = y_vis && !y_reg[0];
  assign hs_raw    = !((x_reg >= X_HS_LO) && (x_reg < X_HS_HI));
  assign vs_raw    = !((y_reg >= Y_VS_LO) && (y_reg < Y_VS_HI));
  assign de_raw    = x_vis && y_vis;
  assign vb_raw    = !y_vis;
  assign col_addr  = LBW'(x_reg >> 1);

  // Reads are issued on even columns; the framebuffer answers one clock
  // later, so the odd column that follows captures entry x/2.
  assign fb_read           = fetch_row && x_vis && !x_reg[0];
  assign wr_en             = fetch_row && x_vis &&  x_reg[0];
  assign fb_reset_read_ptr = (y_reg == Y_VS_LO) && (x_reg == '0);

  // Line buffer (contents deliberately not reset)
  logic [3:0] line_buf [0:LB_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en)
      line_buf[col_addr] <= fb_data;
  end

  // Two delay stages let the even-column pixel wait for its odd-column
  // write; the third stage is the registered line-buffer read, which also
  // registers the sync/blank outputs so all five stay aligned.
  logic [3:0]     ctrl1_reg, ctrl2_reg;   // {hs, vs, de, vb}
  logic [LBW-1:0] addr1_reg, addr2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl1_reg <= 4'b1101;
      ctrl2_reg <= 4'b1101;
      addr1_reg <= '0;
      addr2_reg <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      de        <= 1'b0;
      vblank    <= 1'b1;
      pixel     <= 4'd0;
    end else begin
      ctrl1_reg <= {hs_raw, vs_raw, de_raw, vb_raw};
      ctrl2_reg <= ctrl1_reg;
      addr1_reg <= col_addr;
      addr2_reg <= addr1_reg;
      hsync     <= ctrl2_reg[3];
      vsync     <= ctrl2_reg[2];
      de        <= ctrl2_reg[1];
      vblank    <= ctrl2_reg[0];
      pixel     <= ctrl2_reg[1] ? line_buf[addr2_reg] : 4'd0;
    end
  end

`ifdef FB_SCANOUT_PALETTE_EN
  // Grey ramp; pixel is already 0 outside the visible area.
  assign rgb = {pixel, pixel, pixel};
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Directed testbench for fb_scanout using a reduced raster:
//   line  = 8 + 2 + 3 + 3 = 16 clocks, frame = 6 + 2 + 1 + 2 = 11 lines.
// Framebuffer is 4x3, filled with (a + a/4) mod 16.
module tb_fb_scanout;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 2, VS = 1, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 16
  localparam int VT = VA + VFP + VS + VBP;   // 11
  localparam int FW = HA / 2;                // 4
  localparam int FN = FW * (VA / 2);         // 12

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fb_data = 4'd0;
  logic       fb_read, fb_reset_read_ptr, hsync, vsync, de, vblank;
  logic [3:0] pixel;
`ifdef FB_SCANOUT_PALETTE_EN
  logic [11:0] rgb;
`endif

  int checks = 0;
  int errors = 0;

  fb_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fb_data(fb_data),
    .fb_read(fb_read),
    .fb_reset_read_ptr(fb_reset_read_ptr),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .pixel(pixel),
    .vblank(vblank)
`ifdef FB_SCANOUT_PALETTE_EN
    ,
    .rgb(rgb)
`endif
  );

  always #5 clk = ~clk;

  // Framebuffer model: registered output of ram[pointer of previous cycle]
  logic [3:0] fbmem [0:FN-1];
  int ptr = 0;

  initial begin
    for (int a = 0; a < FN; a++) fbmem[a] = 4'((a + a / 4) % 16);
  end

  always @(posedge clk) begin
    fb_data <= (ptr < FN) ? fbmem[ptr] : 4'd0;
    if (fb_reset_read_ptr) ptr <= 0;
    else if (fb_read)      ptr <= ptr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hsync"}, 32'(hsync), 1);
    check({tag, " vsync"}, 32'(vsync), 1);
    check({tag, " de"}, 32'(de), 0);
    check({tag, " pixel"}, 32'(pixel), 0);
    check({tag, " fb_read"}, 32'(fb_read), 0);
    check({tag, " fb_reset_read_ptr"}, 32'(fb_reset_read_ptr), 0);
    check({tag, " vblank"}, 32'(vblank), 1);
`ifdef FB_SCANOUT_PALETTE_EN
    check({tag, " rgb"}, 32'(rgb), 0);
`endif
    $display("reset check %s: hsync=%0d vsync=%0d de=%0d pixel=%0d vblank=%0d",
             tag, hsync, vsync, de, pixel, vblank);
  endtask

  // Waits (bounded) for the pointer-reset strobe, then observes exactly one
  // frame starting at that cycle (counters at x=0, y=V_ACTIVE+V_FP).
  task automatic run_frame(input string tag, input int exp_wait);
    int k;
    int found = 0;
    int reads_good = 0, reads_bad = 0, rp_cnt = 0, both = 0;
    int de_cnt = 0, hs_lo = 0, vs_lo = 0, vb_cnt = 0, blank_px = 0;
    int first_de = -1, first_hs = -1;
    int pi = 0, row, r, c;
    logic [3:0] img [0:HA*VA-1];
    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (fb_reset_read_ptr) begin
        found = 1;
        break;
      end
    end
    check({tag, " reset_ptr seen"}, 32'(found), 1);
    if (exp_wait >= 0) check({tag, " reset_ptr delay"}, 32'(k), 32'(exp_wait));
    for (int w = 0; w < HT * VT; w++) begin
      if (w > 0) @(negedge clk);
      row = ((VA + VFP) + w / HT) % VT;
      if (fb_read) begin
        if (row < VA && row % 2 == 0) reads_good++;
        else reads_bad++;
      end
      if (fb_reset_read_ptr) rp_cnt++;
      if (fb_read && fb_reset_read_ptr) both++;
      if (!hsync) begin
        hs_lo++;
        if (first_hs < 0) first_hs = w;
      end
      if (!vsync) vs_lo++;
      if (vblank) vb_cnt++;
      if (de) begin
        if (first_de < 0) first_de = w;
        if (de_cnt < HA * VA) img[de_cnt] = pixel;
        de_cnt++;
`ifdef FB_SCANOUT_PALETTE_EN
        check({tag, " rgb grey"}, 32'(rgb), 32'({pixel, pixel, pixel}));
`endif
      end else if (pixel != 4'd0) begin
        blank_px++;
      end
    end
    check({tag, " reads even rows"}, 32'(reads_good), 32'(FN));
    check({tag, " reads odd/blank rows"}, 32'(reads_bad), 0);
    check({tag, " reset_ptr per frame"}, 32'(rp_cnt), 1);
    check({tag, " read with reset_ptr"}, 32'(both), 0);
    check({tag, " de clocks"}, 32'(de_cnt), 48);
    check({tag, " hsync low clocks"}, 32'(hs_lo), 33);
    check({tag, " vsync low clocks"}, 32'(vs_lo), 16);
    check({tag, " vblank clocks"}, 32'(vb_cnt), 80);
    check({tag, " pixel nonzero while blank"}, 32'(blank_px), 0);
    check({tag, " first hsync low offset"}, 32'(first_hs), 13);
    check({tag, " first de offset"}, 32'(first_de), 51);
    if (de_cnt >= HA * VA) begin
      // hand-computed spot values
      check({tag, " r0c0"}, 32'(img[0]), 0);
      check({tag, " r0c1"}, 32'(img[1]), 0);
      check({tag, " r0c2"}, 32'(img[2]), 1);
      check({tag, " r0c3"}, 32'(img[3]), 1);
      check({tag, " r2c0"}, 32'(img[2 * HA]), 5);
      check({tag, " r5c7"}, 32'(img[5 * HA + 7]), 13);
      // every visible pixel against the doubling map
      for (pi = 0; pi < HA * VA; pi++) begin
        r = pi / HA;
        c = pi % HA;
        check({tag, " image"}, 32'(img[pi]),
              32'((((r / 2) * FW + c / 2) + ((r / 2) * FW + c / 2) / 4) % 16));
      end
    end
    $display("frame %s: reads=%0d bad_reads=%0d de=%0d hs_lo=%0d vs_lo=%0d vblank=%0d",
             tag, reads_good, reads_bad, de_cnt, hs_lo, vs_lo, vb_cnt);
  endtask

  initial begin
    // Power-on reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // First frame: pointer reset two rows after release (row 8, x=0)
    run_frame("frame1", HT * (VFP));
    // Back-to-back frame
    run_frame("frame2", -1);

    // Advance into visible row 1 of the next frame, then reset mid-frame
    repeat (HT * 4 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_frame("after_reset", HT * (VFP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
